ascon_perm_sched: RTL and testbench
===================================

# ascon_perm_sched

Shares one Ascon permutation instance (`asconp`) between two requesters, for example the AEAD engine and the hash engine. It round-robin arbitrates valid/ready requests that each carry a full 320-bit state. It then sequences the permutation's `load_init_val`, `rounds_enable` and `round_ctr` through `NUM_ROUNDS` rounds and returns the permuted state to the winning requester over a valid/ready response channel.

## Interface
- `NUM_ROUNDS`, default 12: rounds per request. Passed unchanged to the internal `asconp`. Legal range 1..12.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req0_valid`, `req1_valid`  in  1 each: request offered.
- `req0_ready`, `req1_ready`  out  1 each: request accepted this cycle.
- `req0_state`, `req1_state`  in  320 each: input state, packed as [319:256]=S0, [255:192]=S1, [191:128]=S2, [127:64]=S3, [63:0]=S4.
- `resp0_valid`, `resp1_valid`  out  1 each: result valid for that client.
- `resp0_ready`, `resp1_ready`  in  1 each: client consumes the result.
- `resp_state`  out  320: permuted state, same packing, shared by both clients.
- `busy`  out  1: high in any FSM state other than IDLE.

## Operation
- FSM states:
  - IDLE: if any `reqN_valid` is high, grant one client. Assert its `reqN_ready` and `load_init_val` combinationally in the same cycle, with the `asconp` init inputs muxed from that client's state. Go to RUN and clear `round_ctr` to 0.
  - RUN: `rounds_enable`=1 and `round_ctr` increments every cycle. When `round_ctr`==NUM_ROUNDS-1, go to DONE; `round_ctr` becomes NUM_ROUNDS.
  - DONE: `rounds_enable`=0 and `round_ctr` holds at NUM_ROUNDS, so `rounds_done`=1 and the `asconp` registers hold. Assert `respG_valid` for the granted client G. When `respG_ready` is high, go to IDLE; `round_ctr` stays at NUM_ROUNDS until the next grant.
- Arbitration: round-robin over 2 clients with a 1-bit last-grant pointer.
  - Both requesting: grant the client that is not the last grantee.
  - Only one requesting: grant it, regardless of the pointer.
  - The pointer updates only on a grant.
- `reqN_ready` is high only in IDLE and only for the granted client. It is never high for both clients in the same cycle.
- `resp_state` = `{S_0_reg..S_4_reg}` of `asconp` at all times. It is only meaningful while a `respN_valid` is high.
- A request arriving in RUN or DONE waits; `reqN_valid` must be held by the client (standard valid/ready).
- Only one request is in flight at a time; there is no pipelining.

## Timing
- Reset values:
  - state IDLE
  - `round_ctr`=NUM_ROUNDS (permutation idle)
  - last-grant pointer=1, so client 0 wins the first tie
  - all `ready` and `valid` outputs 0, `busy`=0
  - `asconp` state 0
- Acceptance in cycle T:
  - `asconp` loads at the T edge.
  - Rounds execute in cycles T+1..T+NUM_ROUNDS, with `round_ctr` 0..NUM_ROUNDS-1.
  - `respG_valid` is high from cycle T+NUM_ROUNDS+1.
  - Latency is NUM_ROUNDS+1 cycles (13 for the default).
- Response accepted in cycle R: IDLE in R+1, and a new grant is possible in R+1. Minimum request-to-request spacing is NUM_ROUNDS+2 cycles.
- `respG_valid` held with `respG_ready` low: stay in DONE indefinitely, with `resp_state` stable.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE. The in-flight result is discarded, no `resp_valid` is raised, and `asconp` is cleared.
- Client deasserts `reqN_valid` without being granted: no effect. A grant in IDLE is decided on same-cycle `valid` only.

## Structure
- Shared package `ascon_pkg`:
  - `ASCON_STATE_W`=320
  - `ASCON_LANE_W`=64
  - default `NUM_ROUNDS`
  - FSM state enum {IDLE, RUN, DONE}
  - pack/unpack functions between 320-bit vectors and five 64-bit lanes
- Sub-module: exactly one instance of `asconp`. The scheduler owns the `round_ctr` register and drives `load_init_val` and `rounds_enable`.

## Test plan
- Single request: client 0 offers state `0x00..01` in cycle 5 → `req0_ready`=1 in cycle 5, `resp0_valid` rises in cycle 18, and `resp_state` equals the golden Ascon-p[12] of the input.
- Simultaneous requests from both clients after reset → client 0 is granted first. Client 1 gets `req1_ready` exactly 1 cycle after client 0's response handshake. Both results match the golden model.
- Back-to-back requests from client 1 alone, with `resp1_ready` tied high → a grant every 14 cycles. The round-robin pointer never starves client 1.
- Back-pressure: `resp0_ready` held low for 20 cycles → `resp0_valid` and `resp_state` stay stable, `round_ctr`=12, and `req1_ready` stays 0 throughout.
- Reset pulse at round 6 → `busy`=0 and all outputs return to reset values. A subsequent request completes correctly in 13 cycles.
- `NUM_ROUNDS`=6 build → latency is 7 cycles, and the result matches golden Ascon-p[6] using round constants 0x96..0x4b.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: widths, scheduler states, lane packing and the
// single-round permutation function used by asconp.
package ascon_pkg;

  localparam int ASCON_STATE_W    = 320;
  localparam int ASCON_LANE_W     = 64;
  localparam int ASCON_MAX_ROUNDS = 12;
  localparam int ASCON_NUM_ROUNDS = 12;
  localparam int ASCON_CTR_W      = 4;

  typedef logic [ASCON_LANE_W-1:0] lane_t;
  typedef lane_t [0:4] lanes_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // Lane 0 (S0) occupies the most significant 64 bits.
  function automatic lanes_t unpack_state(input logic [ASCON_STATE_W-1:0] v);
    lanes_t l;
    for (int i = 0; i < 5; i++) l[i] = v[ASCON_STATE_W-1-ASCON_LANE_W*i -: ASCON_LANE_W];
    return l;
  endfunction

  function automatic logic [ASCON_STATE_W-1:0] pack_state(input lanes_t l);
    logic [ASCON_STATE_W-1:0] v;
    for (int i = 0; i < 5; i++) v[ASCON_STATE_W-1-ASCON_LANE_W*i -: ASCON_LANE_W] = l[i];
    return v;
  endfunction

  function automatic lane_t ror(input lane_t x, input int n);
    return (x >> n) | (x << (ASCON_LANE_W - n));
  endfunction

  function automatic lanes_t ascon_round(input lanes_t s, input logic [7:0] rc);
    lane_t x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    lanes_t r;
    x0 = s[0]; x1 = s[1]; x2 = s[2] ^ {56'd0, rc}; x3 = s[3]; x4 = s[4];
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    r[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    r[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    r[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    r[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    r[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return r;
  endfunction

endpackage

// File: rtl/asconp.sv
// One-round-per-cycle Ascon permutation core. The round counter is owned
// by the caller; the registers hold once the counter reaches NUM_ROUNDS.
module asconp
  import ascon_pkg::*;
#(
  parameter int NUM_ROUNDS = ASCON_NUM_ROUNDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_init_val_i,
  input  logic                     rounds_enable_i,
  input  logic [ASCON_CTR_W-1:0]   round_ctr_i,
  input  logic [ASCON_STATE_W-1:0] init_state_i,
  output logic [ASCON_STATE_W-1:0] state_o,
  output logic                     rounds_done_o
);

  // Reduced-round variants use the last NUM_ROUNDS constants of the schedule.
  localparam logic [ASCON_CTR_W-1:0] RC_OFS = ASCON_CTR_W'(ASCON_MAX_ROUNDS - NUM_ROUNDS);

  lanes_t                 s_q;
  logic [ASCON_CTR_W-1:0] rc_idx;
  logic [7:0]             rc;

  assign rc_idx        = round_ctr_i + RC_OFS;
  assign rc            = {4'hf - rc_idx, rc_idx};
  assign rounds_done_o = (round_ctr_i == ASCON_CTR_W'(NUM_ROUNDS));
  assign state_o       = pack_state(s_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else if (load_init_val_i) begin
      s_q <= unpack_state(init_state_i);
    end else if (rounds_enable_i && !rounds_done_o) begin
      s_q <= ascon_round(s_q, rc);
    end
  end

endmodule

// File: rtl/ascon_perm_sched.sv
// Round-robin scheduler sharing one asconp between two valid/ready clients;
// one request in flight, result returned to the granted client.
module ascon_perm_sched
  import ascon_pkg::*;
#(
  parameter int NUM_ROUNDS = ASCON_NUM_ROUNDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [ASCON_STATE_W-1:0] req0_state,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [ASCON_STATE_W-1:0] req1_state,
  output logic                     resp0_valid,
  input  logic                     resp0_ready,
  output logic                     resp1_valid,
  input  logic                     resp1_ready,
  output logic [ASCON_STATE_W-1:0] resp_state,
  output logic                     busy
);

  localparam logic [ASCON_CTR_W-1:0] LAST_RND = ASCON_CTR_W'(NUM_ROUNDS - 1);
  localparam logic [ASCON_CTR_W-1:0] END_CNT  = ASCON_CTR_W'(NUM_ROUNDS);

  sched_state_e           state_q, state_d;
  logic [ASCON_CTR_W-1:0] round_ctr_q, round_ctr_d;
  logic                   last_q, last_d;
  logic                   gnt1;
  logic                   load_init_val, rounds_enable, rounds_done;
  logic [ASCON_STATE_W-1:0] init_state;

  // last_q doubles as the grant of the request currently in flight.
  assign gnt1       = req1_valid & (~req0_valid | ~last_q);
  assign init_state = gnt1 ? req1_state : req0_state;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    round_ctr_d   = round_ctr_q;
    last_d        = last_q;
    load_init_val = 1'b0;
    rounds_enable = 1'b0;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    resp0_valid   = 1'b0;
    resp1_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          load_init_val = 1'b1;
          req0_ready    = ~gnt1;
          req1_ready    = gnt1;
          last_d        = gnt1;
          round_ctr_d   = '0;
          state_d       = RUN;
        end
      end
      RUN: begin
        rounds_enable = 1'b1;
        round_ctr_d   = round_ctr_q + 1'b1;
        if (round_ctr_q == LAST_RND) state_d = DONE;
      end
      DONE: begin
        resp0_valid = rounds_done & ~last_q;
        resp1_valid = rounds_done & last_q;
        if (last_q ? resp1_ready : resp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_ctr_q <= END_CNT;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      round_ctr_q <= round_ctr_d;
      last_q      <= last_d;
    end
  end

  asconp #(.NUM_ROUNDS(NUM_ROUNDS)) u_asconp (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_init_val_i (load_init_val),
    .rounds_enable_i (rounds_enable),
    .round_ctr_i     (round_ctr_q),
    .init_state_i    (init_state),
    .state_o         (resp_state),
    .rounds_done_o   (rounds_done)
  );

endmodule

// File: tb/tb_ascon_perm_sched.sv
// Directed bench for ascon_perm_sched: default 12-round build plus a
// 6-round build, against a table-driven S-box reference permutation.
module tb_ascon_perm_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         r0v, r1v, p0r, p1r, r0rdy, r1rdy, p0v, p1v, busy;
  logic [319:0] r0s, r1s, rs;
  logic         e0v, e1v, e0r, e1r, e0rdy, e1rdy, f0v, f1v, e_busy;
  logic [319:0] e0s, e1s, e_rs;

  ascon_perm_sched u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_state(r0s),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_state(r1s),
    .resp0_valid(p0v), .resp0_ready(p0r),
    .resp1_valid(p1v), .resp1_ready(p1r),
    .resp_state(rs), .busy(busy)
  );

  ascon_perm_sched #(.NUM_ROUNDS(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(e0v), .req0_ready(e0rdy), .req0_state(e0s),
    .req1_valid(e1v), .req1_ready(e1rdy), .req1_state(e1s),
    .resp0_valid(f0v), .resp0_ready(e0r),
    .resp1_valid(f1v), .resp1_ready(e1r),
    .resp_state(e_rs), .busy(e_busy)
  );

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic logic [63:0] rot(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] golden(input logic [319:0] in, input int nr);
    logic [63:0]  x [5];
    logic [4:0]   v, o;
    logic [7:0]   rc;
    logic [319:0] res;
    for (int i = 0; i < 5; i++) x[i] = in[319-64*i -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      rc   = 8'(((15 - r) << 4) | r);
      x[2] = x[2] ^ {56'd0, rc};
      for (int b = 0; b < 64; b++) begin
        v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = SBOX[v];
        x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
      end
      x[0] = x[0] ^ rot(x[0], 19) ^ rot(x[0], 28);
      x[1] = x[1] ^ rot(x[1], 61) ^ rot(x[1], 39);
      x[2] = x[2] ^ rot(x[2], 1)  ^ rot(x[2], 6);
      x[3] = x[3] ^ rot(x[3], 10) ^ rot(x[3], 17);
      x[4] = x[4] ^ rot(x[4], 7)  ^ rot(x[4], 41);
    end
    for (int i = 0; i < 5; i++) res[319-64*i -: 64] = x[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Latency counted from the acceptance cycle; exceeds budget on a hang.
  task automatic wait_v(input int which, output int lat);
    logic s;
    lat = 1;
    forever begin
      case (which)
        0:       s = p0v;
        1:       s = p1v;
        default: s = f1v;
      endcase
      if (s || lat >= 40) break;
      tick();
      lat++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [319:0] sa, sb, sc, sd, se, hold_ref;
  int           lat, k, prev;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    sa = 320'h1;
    sb = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
          64'h8796a5b4c3d2e1f0, 64'hdeadbeefcafebabe};
    sc = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
          64'h4444444444444444, 64'h5555555555555555};
    sd = {64'h80400c0600000000, 64'h0, 64'h0, 64'h0, 64'hffffffffffffffff};
    se = {64'ha5a5a5a5a5a5a5a5, 64'h5a5a5a5a5a5a5a5a, 64'h0, 64'h0123, 64'h8000000000000000};
    {r0v, r1v, p0r, p1r, e0v, e1v, e0r, e1r} = '0;
    r0s = '0; r1s = '0; e0s = '0; e1s = '0;
    rst_n = 1'b0;
    tick(); tick();

    chk("rst_busy",  {busy, e_busy}, 2'b00);
    chk("rst_outs",  {r0rdy, r1rdy, p0v, p1v, f0v, f1v}, 6'b0);
    chk("rst_state", rs, 320'h0);
    chk("rst_ctr",   u_dut.round_ctr_q, 12);
    rst_n = 1'b1;
    tick(); tick(); tick();

    // single request from client 0
    r0s = sa; r0v = 1'b1; #1;
    chk("t1_grant", {r0rdy, r1rdy, busy}, 3'b100);
    tick(); r0v = 1'b0;
    chk("t1_busy", busy, 1'b1);
    wait_v(0, lat);
    chk("t1_lat",   lat, 13);
    chk("t1_state", rs, golden(sa, 12));
    p0r = 1'b1; tick(); p0r = 1'b0;
    chk("t1_idle", {busy, p0v}, 2'b00);

    // simultaneous requests after reset: client 0 first
    do_reset();
    r0s = sb; r1s = sc; r0v = 1'b1; r1v = 1'b1; #1;
    chk("t2_grant0", {r0rdy, r1rdy}, 2'b10);
    tick(); r0v = 1'b0; #1;
    chk("t2_wait1", r1rdy, 1'b0);
    wait_v(0, lat);
    chk("t2_lat0",   lat, 13);
    chk("t2_state0", rs, golden(sb, 12));
    p0r = 1'b1; #1;
    chk("t2_hold1", r1rdy, 1'b0);
    tick(); p0r = 1'b0; #1;
    chk("t2_grant1", {r0rdy, r1rdy}, 2'b01);
    tick(); r1v = 1'b0;
    wait_v(1, lat);
    chk("t2_lat1",   lat, 13);
    chk("t2_state1", rs, golden(sc, 12));
    chk("t2_only1",  p0v, 1'b0);
    p1r = 1'b1; tick(); p1r = 1'b0;

    // back-to-back from client 1 alone with resp1_ready high
    r1s = sd; r1v = 1'b1; p1r = 1'b1; prev = 0;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      while (!r1rdy && k < 30) begin tick(); k++; end
      chk("t3_rdy", {r0rdy, r1rdy}, 2'b01);
      if (g > 0) chk("t3_gap", cyc - prev, 14);
      prev = cyc;
      tick();
    end
    r1v = 1'b0;
    wait_v(1, lat);
    chk("t3_lat",   lat, 13);
    chk("t3_state", rs, golden(sd, 12));
    tick(); p1r = 1'b0;
    chk("t3_idle", busy, 1'b0);

    // back-pressure on client 0 while client 1 waits
    r0s = se; r0v = 1'b1; tick(); r0v = 1'b0;
    r1s = sb; r1v = 1'b1;
    wait_v(0, lat);
    chk("t4_lat",   lat, 13);
    chk("t4_state", rs, golden(se, 12));
    hold_ref = rs;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_hold",   {p0v, r1rdy, u_dut.round_ctr_q}, {1'b1, 1'b0, 4'd12});
      chk("t4_stable", rs, hold_ref);
    end
    r1v = 1'b0; p0r = 1'b1; tick(); p0r = 1'b0;
    chk("t4_idle", {busy, p0v}, 2'b00);

    // reset in the middle of the rounds
    r0s = sc; r0v = 1'b1; tick(); r0v = 1'b0;
    k = 0;
    while (u_dut.round_ctr_q != 4'd6 && k < 20) begin tick(); k++; end
    chk("t5_round6", u_dut.round_ctr_q, 6);
    rst_n = 1'b0; #1;
    chk("t5_busy",  busy, 1'b0);
    chk("t5_outs",  {r0rdy, r1rdy, p0v, p1v}, 4'b0);
    chk("t5_state", rs, 320'h0);
    chk("t5_ctr",   u_dut.round_ctr_q, 12);
    tick(); rst_n = 1'b1; tick();
    r0s = sd; r0v = 1'b1; #1;
    chk("t5_grant", r0rdy, 1'b1);
    tick(); r0v = 1'b0;
    wait_v(0, lat);
    chk("t5_lat",     lat, 13);
    chk("t5_result",  rs, golden(sd, 12));
    p0r = 1'b1; tick(); p0r = 1'b0;

    // reduced-round build
    e1s = sb; e1v = 1'b1; #1;
    chk("t6_grant", {e0rdy, e1rdy}, 2'b01);
    tick(); e1v = 1'b0;
    wait_v(2, lat);
    chk("t6_lat",   lat, 7);
    chk("t6_state", e_rs, golden(sb, 6));
    e1r = 1'b1; tick(); e1r = 1'b0;
    chk("t6_idle", {e_busy, f1v}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
